// File: rtl/sram_mem_controller.sv
// Memory-stage controller: splits one 32-bit load/store into two 16-bit accesses
// on an asynchronous SRAM and freezes the pipeline through `ready` while busy.
module sram_mem_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  // state | meaning
  // IDLE  | waiting for a load/store request; op, word and data latched on entry to LOW
  // LOW   | low half-word on the bus for HOLD_CYCLES cycles
  // HIGH  | high half-word on the bus for HOLD_CYCLES cycles
  // DONE  | access complete; ready released for exactly this cycle
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam int            CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          op_wr;
  logic [16:0]   word;
  logic [31:0]   wdata;
  logic [31:0]   off;
  logic          req;
  logic          phase_end;
  logic          dq_oe;
  logic [15:0]   dq_out;
  logic          unused_off_bits;

  assign off             = address - 32'(BASE_ADDR);
  assign unused_off_bits = ^{off[31:19], off[1:0]};
  assign req             = wr_en | rd_en;
  assign phase_end       = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dq_oe     = 1'b0;
    dq_out    = wdata[15:0];
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        dq_oe  = op_wr;
        dq_out = wdata[15:0];
        if (phase_end) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH: begin
        dq_oe  = op_wr;
        dq_out = wdata[31:16];
        if (phase_end) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request fields are captured once so the access completes even if the enables change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr     <= 1'b0;
      word      <= '0;
      wdata     <= '0;
      SRAM_ADDR <= '0;
      read_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            op_wr     <= wr_en;
            word      <= off[18:2];
            wdata     <= write_data;
            SRAM_ADDR <= {off[18:2], 1'b0};
          end
        end
        LOW: begin
          if (phase_end) begin
            SRAM_ADDR <= {word, 1'b1};
            if (!op_wr) read_data[15:0] <= SRAM_DQ;
          end
        end
        HIGH: begin
          if (phase_end && !op_wr) read_data[31:16] <= SRAM_DQ;
        end
        default: ;
      endcase
    end
  end

  assign ready     = ~(req & (state != DONE));
  assign SRAM_DQ   = dq_oe ? dq_out : {16{1'bz}};
  assign SRAM_WE_N = ~dq_oe;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: directed loads/stores against a small SRAM model,
// with a scoreboard monitor checking write strobes, stall length and load data.
module tb_sram_mem_controller;

  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  tri1  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  sram_mem_controller #(.BASE_ADDR(1024), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
    .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
    .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n)
  );

  always #5 clk = ~clk;

  // SRAM model: 16 half-words, drives the bus only while a load is in progress
  logic [15:0] mem [0:15];
  logic        mem_init = 1'b1;
  logic        sram_drive = 1'b0;

  assign sram_dq = (sram_drive && sram_we_n) ? mem[sram_addr[3:0]] : {16{1'bz}};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'hA000 + 16'(i);
    end else if (!sram_we_n) begin
      mem[sram_addr[3:0]] <= sram_dq;
    end
  end

  typedef struct { logic [17:0] addr; logic [15:0] dq; } wr_t;
  typedef struct { logic [31:0] rdata; int gap; } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT strobes a write or releases ready.
  int    stall = 0;
  int    high_run = 0;
  int    last_gap = 0;
  wr_t   w;
  done_t d;

  always @(negedge clk) begin
    if (rst) begin
      stall    = 0;
      high_run = 0;
    end else begin
      if (sram_we_n === 1'b0) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write actual=addr %h dq %h required=no write", sram_addr, sram_dq);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(sram_addr), 32'(w.addr));
          chk("wr_dq", 32'(sram_dq), 32'(w.dq));
        end
      end
      if (!ready) begin
        if (stall == 0) begin
          last_gap = high_run;
          high_run = 0;
        end
        stall++;
      end else begin
        if (stall > 0) begin
          if (exp_done.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done actual=stall %0d required=no access", stall);
          end else begin
            d = exp_done.pop_front();
            chk("stall_len", 32'(stall), 32'(2 * H + 1));
            chk("read_data", read_data, d.rdata);
            if (d.gap >= 0) chk("ready_gap", 32'(last_gap), 32'(d.gap));
          end
          stall = 0;
        end
        high_run++;
      end
    end
  end

  // Issues one access at posedge+1 and returns one cycle after ready rises.
  task automatic do_op(input logic w_i, input logic r_i, input logic [31:0] a,
                       input logic [31:0] wd, input logic [17:0] lo_addr,
                       input logic [31:0] exp_rd, input int gap, input bit keep);
    int n;
    wr_en      = w_i;
    rd_en      = r_i;
    address    = a;
    write_data = wd;
    sram_drive = r_i & ~w_i;
    if (w_i) begin
      for (int i = 0; i < H; i++) exp_wr.push_back('{addr: lo_addr, dq: wd[15:0]});
      for (int i = 0; i < H; i++) exp_wr.push_back('{addr: lo_addr + 18'd1, dq: wd[31:16]});
    end
    exp_done.push_back('{rdata: exp_rd, gap: gap});
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ready) break;
    end
    if (n == 30) begin
      total++; bad++;
      $display("FAIL ready_timeout actual=ready low 30 cycles required=ready within %0d", 2 * H + 1);
    end
    @(posedge clk); #1;
    if (!keep) begin
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      sram_drive = 1'b0;
    end
  endtask

  initial begin
    #3;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_dq_released", 32'(sram_dq), 32'h0000FFFF);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    mem_init = 1'b0;

    do_op(1, 0, 32'd1024, 32'hDEADBEEF, 18'd0, 32'h00000000, -1, 0);
    chk("addr_hold_after_store", 32'(sram_addr), 32'd1);
    chk("idle_dq_released", 32'(sram_dq), 32'h0000FFFF);
    do_op(0, 1, 32'd1024, 32'h0,        18'd0, 32'hDEADBEEF, -1, 0);
    do_op(1, 0, 32'd1028, 32'h12345678, 18'd2, 32'hDEADBEEF, -1, 0);
    do_op(0, 1, 32'd1028, 32'h0,        18'd2, 32'h12345678, -1, 0);
    do_op(1, 1, 32'd1024, 32'hCAFEF00D, 18'd0, 32'h12345678, -1, 0);
    do_op(0, 1, 32'd1036, 32'h0,        18'd6, 32'hA007A006, -1, 0);
    do_op(0, 1, 32'd1024, 32'h0,        18'd0, 32'hCAFEF00D, -1, 1);
    do_op(1, 0, 32'd1032, 32'h0BADC0DE, 18'd4, 32'hCAFEF00D,  1, 0);
    chk("addr_hold_after_b2b", 32'(sram_addr), 32'd5);

    // reset during the first HIGH cycle of a store to word 5 (half-words 10/11)
    wr_en      = 1'b1;
    address    = 32'd1044;
    write_data = 32'h11112222;
    for (int i = 0; i < H; i++) exp_wr.push_back('{addr: 18'd10, dq: 16'h2222});
    repeat (H + 1) @(posedge clk);
    #2;
    rst   = 1'b1;
    wr_en = 1'b0;
    #1;
    chk("midrst_we_n", 32'(sram_we_n), 32'd1);
    chk("midrst_dq_released", 32'(sram_dq), 32'h0000FFFF);
    chk("midrst_read_data", read_data, 32'd0);
    chk("midrst_sram_addr", 32'(sram_addr), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle_ready", 32'(ready), 32'd1);

    do_op(0, 1, 32'd1024, 32'h0, 18'd0, 32'hCAFEF00D, -1, 0);
    repeat (3) @(posedge clk);
    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_done.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Memory-stage controller between the EX/MEM pipeline register and the board's 16-bit asynchronous SRAM. It turns one 32-bit load or store, issued from the registered ALU result, store value and read/write enables, into two 16-bit SRAM half-word accesses. While an access is in flight it deasserts `ready`, which the hazard logic uses as the pipeline freeze. It returns the assembled 32-bit load data to the MEM/WB register.

## Interface
- `BASE_ADDR`, default 1024: data-memory base; subtracted from `address` before mapping.
- `HOLD_CYCLES`, default 2: cycles each half-word phase is held on the SRAM bus, minimum 1.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: store request, from the EX/MEM MEM_W_EN output.
- `rd_en` in 1: load request, from the EX/MEM MEM_R_en output.
- `address` in 32: byte address, from the EX/MEM ALU result.
- `write_data` in 32: store value.
- `read_data` out 32: assembled load word.
- `ready` out 1: 0 = access in progress; the pipeline must freeze.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_WE_N` out 1: SRAM write enable, active-low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` out 1 each: tied to 0.

## Operation
- **Address map**
  - `off = address - BASE_ADDR`, modulo 2^32.
  - `word = off[18:2]` (17 bits).
  - Low-half SRAM address = `{word, 1'b0}`; high-half SRAM address = `{word, 1'b1}`.
  - `off[1:0]` is ignored; accesses are word-aligned.
- **States:** `IDLE`, `LOW`, `HIGH`, `DONE`. A phase counter of width ceil(log2(`HOLD_CYCLES`+1)) runs in `LOW` and `HIGH`.
- **IDLE**
  - If `wr_en | rd_en`: latch op, word and `write_data`, clear the counter, go to `LOW`.
  - Write wins when both enables are set; the op is a store and `read_data` is unchanged.
- **LOW**
  - `SRAM_ADDR` = low-half address.
  - Store: drive `SRAM_DQ` = data[15:0] and `SRAM_WE_N` = 0.
  - Load: `SRAM_DQ` = Z and `SRAM_WE_N` = 1.
  - After `HOLD_CYCLES` cycles go to `HIGH`. A load captures `SRAM_DQ` into `read_data[15:0]` on that edge.
- **HIGH**
  - Same as `LOW`, using the high-half address and data[31:16].
  - A load captures into `read_data[31:16]` on the exit edge.
  - Next state is `DONE`.
- **DONE**
  - `SRAM_WE_N` = 1 and `SRAM_DQ` = Z.
  - Next state is `IDLE` unconditionally.
- **ready** is combinational: `ready = ~((wr_en | rd_en) & state != DONE)`.
  - It falls in the same cycle a request appears in `IDLE`.
  - It rises exactly in `DONE`, so the pipeline advances one instruction.
- **Mid-operation behaviour**
  - Op, address and data are latched in `IDLE`. Changing or dropping the enables mid-operation does not abort the access; it always finishes through `DONE`.
- **Outside `LOW` and `HIGH`:** `SRAM_DQ` = Z, `SRAM_WE_N` = 1, and `SRAM_ADDR` holds its last value.
- **read_data** holds its value until overwritten by the next load's capture.

## Timing
- **Reset values:** state `IDLE`, counter 0, `read_data` 0, `SRAM_ADDR` 0, `SRAM_WE_N` 1, `SRAM_DQ` Z. `ready` is 1 when no request is present.
- **Request at cycle 0** (in `IDLE`):
  - `LOW` during cycles 1..H.
  - `HIGH` during cycles H+1..2H.
  - `DONE` at cycle 2H+1.
  - `ready` is 0 for cycles 0..2H, i.e. 2H+1 stall cycles. With H = 2 that is 5 stall cycles, and `ready` is 1 in cycle 5.
- **Load data:** `read_data` is complete from cycle 2H+1 onward, valid when `ready` rises.
- **Back-to-back requests:** a new request present in `DONE` is seen in `IDLE` on the next cycle, so `ready` is high for exactly one cycle between accesses.
- **Reset mid-operation:** asynchronous `rst` forces the reset values immediately; a half-written word may remain in the SRAM.
- **SRAM model:** read data must be valid within `HOLD_CYCLES` cycles of the address change.

## Test plan
- **Reset:** assert `rst`, no request → `ready` = 1, `read_data` = 0, `SRAM_WE_N` = 1, `SRAM_DQ` = Z.
- **Store:** `wr_en` = 1, address 1024, data 0xDEADBEEF, H = 2 →
  - `SRAM_ADDR` 0 with DQ 0xBEEF and `WE_N` = 0 for 2 cycles.
  - Then `SRAM_ADDR` 1 with DQ 0xDEAD for 2 cycles.
  - `ready` is 0 for 5 cycles, then 1.
- **Load-after-store:** `rd_en` = 1, address 1024 → `read_data` = 0xDEADBEEF when `ready` rises. Address 1028 maps to `SRAM_ADDR` 2 and 3.
- **Both enables set:** `wr_en` = `rd_en` = 1 → store performed, `read_data` unchanged.
- **Back-to-back:** back-to-back load then store → `ready` high exactly one cycle between the two 5-cycle stalls.
- **Reset mid-access:** `rst` pulsed during `HIGH` → `SRAM_WE_N` = 1 and `SRAM_DQ` = Z immediately; state `IDLE`; `read_data` = 0.
